// File: rtl/spi_sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI SRAM master request port.
// Define SPI_SRAM_ARB_FIXED_PRIO_EN to give port 0 fixed priority on contention.
module spi_sram_arbiter #(
    parameter int AW = 24,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_wr,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_ack,
    input  logic          p1_req,
    input  logic          p1_wr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_ack,
    output logic          m_en,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          grant,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state, state_nxt;
    logic          last;
    logic          win;
    logic          any_req;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    assign any_req = p0_req | p1_req;

`ifdef SPI_SRAM_ARB_FIXED_PRIO_EN
    // last keeps tracking grants but never influences the choice
    assign win = p1_req & ~p0_req;
`else
    assign win = (p0_req & p1_req) ? ~last : p1_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ISSUE;
            S_ISSUE: if (m_ready) state_nxt = S_WAIT;
            S_WAIT:  if (m_ready) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 1'b1;
            grant    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            if (state == S_IDLE && any_req) begin
                last    <= win;
                grant   <= win;
                wr_q    <= win ? p1_wr    : p0_wr;
                addr_q  <= win ? p1_addr  : p0_addr;
                wdata_q <= win ? p1_wdata : p0_wdata;
            end
            // read data is only captured on completion of a read
            if (state == S_WAIT && m_ready && !wr_q) begin
                if (grant) p1_rdata <= m_rdata;
                else       p0_rdata <= m_rdata;
            end
        end
    end

    assign m_en    = (state == S_ISSUE);
    assign m_wr    = wr_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign busy    = (state != S_IDLE);
    assign p0_ack  = (state == S_DONE) & ~grant;
    assign p1_ack  = (state == S_DONE) &  grant;
endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Bench for spi_sram_arbiter: behavioural SPI master, transaction-level scoreboard.
module tb_spi_sram_arbiter;
    localparam int AW = 24;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          p0_req, p0_wr, p0_ack, p1_req, p1_wr, p1_ack;
    logic [AW-1:0] p0_addr, p1_addr, m_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, m_wdata, m_rdata;
    logic          m_en, m_wr, m_ready, grant, busy;

    logic          req_v   [2];
    logic          wr_v    [2];
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];

    assign p0_req = req_v[0];  assign p0_wr = wr_v[0];
    assign p0_addr = addr_v[0]; assign p0_wdata = wdata_v[0];
    assign p1_req = req_v[1];  assign p1_wr = wr_v[1];
    assign p1_addr = addr_v[1]; assign p1_wdata = wdata_v[1];

    spi_sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .grant(grant), .busy(busy)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          acc_q[$];
    logic [DW-1:0] mem     [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_rd  [2];
    logic          last_m;
    int total = 0, bad = 0;
    int lat_m = 1, stall_n = 0, en_cnt = 0, ack_cnt = 0;

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Behavioural SPI SRAM master: ready when idle, completes lat_m cycles after accept.
    initial begin : master
        txn_t          t;
        logic [AW-1:0] sa;
        int            lat;
        m_ready = 1'b1;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ready = 1'b1;
            end else begin
                if (m_en && m_ready && stall_n > 0) begin
                    sa = m_addr;
                    m_ready = 1'b0;
                    for (int i = 0; i < stall_n; i++) begin
                        @(negedge clk);
                        chk("stall_en", m_en, 1);
                        chk("stall_addr", m_addr, sa);
                    end
                    stall_n = 0;
                    m_ready = 1'b1;
                end
                if (m_en && m_ready) begin
                    t.wr = m_wr; t.addr = m_addr; t.wdata = m_wdata;
                    acc_q.push_back(t);
                    lat = lat_m;
                    @(posedge clk); #1;
                    for (int i = 1; i < lat && !rst; i++) begin
                        m_ready = 1'b0;
                        chk("wait_en", m_en, 0);
                        chk("wait_hold", {m_wr, m_addr, m_wdata}, {t.wr, t.addr, t.wdata});
                        @(posedge clk); #1;
                    end
                    if (!rst) begin
                        if (t.wr) begin
                            mem[t.addr] = t.wdata;
                            m_rdata = DW'($urandom);
                        end else begin
                            m_rdata = mem.exists(t.addr) ? mem[t.addr] : init_val(t.addr);
                        end
                    end
                    m_ready = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_en) en_cnt++;
        if (!rst && (p0_ack || p1_ack)) begin
            ack_cnt++;
            chk("ack_vs_grant", {p1_ack, p0_ack}, {grant, ~grant});
        end
    end

    task automatic set_req(int p, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
        req_v[p] = 1'b1; wr_v[p] = wr; addr_v[p] = a; wdata_v[p] = d;
    endtask

    task automatic new_req(int p);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 1) ? 24'hFFFFF0 : 24'h0) | AW'($urandom_range(0, 15));
        set_req(p, 1'($urandom_range(0, 1)), a, DW'($urandom));
    endtask

    // Waits for the next ack and checks it against the arbitration/memory model.
    task automatic service(output int w, output int lat);
        int   obs;
        txn_t t;
        if (req_v[0] && req_v[1]) begin
`ifdef SPI_SRAM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = last_m ? 0 : 1;
`endif
        end else begin
            w = req_v[1] ? 1 : 0;
        end
        last_m = w[0];
        lat = 0;
        obs = -1;
        while (obs < 0 && lat < 300) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (p0_ack) obs = 0;
            else if (p1_ack) obs = 1;
        end
        chk("ack_port", obs, w);
        if (obs < 0) return;
        chk("grant", grant, w);
        chk("acc_count", acc_q.size(), 1);
        if (acc_q.size() == 0) return;
        t = acc_q.pop_front();
        chk("acc_wr", t.wr, wr_v[w]);
        chk("acc_addr", t.addr, addr_v[w]);
        if (wr_v[w]) begin
            chk("acc_wdata", t.wdata, wdata_v[w]);
            ref_mem[addr_v[w]] = wdata_v[w];
        end else begin
            exp_rd[w] = ref_mem.exists(addr_v[w]) ? ref_mem[addr_v[w]] : init_val(addr_v[w]);
        end
        chk(w ? "p1_rdata" : "p0_rdata", w ? p1_rdata : p0_rdata, exp_rd[w]);
    endtask

    initial begin
        int w, lat, snap;
        last_m = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        mem[24'h000200] = 8'hA5; ref_mem[24'h000200] = 8'hA5;

        // reset with both requesting
        rst = 1'b1;
        set_req(0, 1'b0, 24'h000040, 8'h00);
        set_req(1, 1'b0, 24'h000041, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_en", m_en, 0);       chk("rst_m_wr", m_wr, 0);
        chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
        chk("rst_acks", {p0_ack, p1_ack}, 0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        chk("rst_grant", grant, 0);     chk("rst_busy", busy, 0);
        rst = 1'b0;
        service(w, lat);
        chk("first_tie_port", w, 0);
        req_v[0] = 1'b0;
        service(w, lat);
        req_v[1] = 1'b0;
        repeat (2) @(negedge clk);

        // single read, L=20
        lat_m = 20; snap = en_cnt;
        set_req(0, 1'b0, 24'h000200, 8'h00);
        service(w, lat);
        req_v[0] = 1'b0;
        chk("read_latency", lat, 22);
        chk("read_en_cycles", en_cnt - snap, 1);
        chk("read_data", p0_rdata, 8'hA5);
        repeat (2) @(negedge clk);

        // single write from port 1, L=5
        lat_m = 5; snap = ack_cnt;
        set_req(1, 1'b1, 24'h00FFFC, 8'h04);
        service(w, lat);
        req_v[1] = 1'b0;
        chk("write_latency", lat, 7);
        repeat (3) @(negedge clk);
        chk("write_ack_once", ack_cnt - snap, 1);

        // contention: both hold req for 6 transfers
        lat_m = 3;
        new_req(0); new_req(1);
        for (int k = 0; k < 6; k++) begin
            service(w, lat);
            new_req(w);
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        repeat (4) @(negedge clk);

        // master stall of 5 cycles in ISSUE
        lat_m = 3; stall_n = 5;
        set_req(0, 1'b1, 24'h123456, 8'h77);
        service(w, lat);
        req_v[0] = 1'b0;
        chk("stall_latency", lat, 10);
        repeat (2) @(negedge clk);

        // randomized traffic
        new_req(0);
        for (int k = 0; k < 40; k++) begin
            service(w, lat);
            lat_m = $urandom_range(1, 6);
            if ($urandom_range(0, 3) == 0) stall_n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) != 0) new_req(w);
            else req_v[w] = 1'b0;
            if (!req_v[1 - w] && $urandom_range(0, 1) != 0) new_req(1 - w);
            if (!req_v[0] && !req_v[1]) new_req(int'($urandom_range(0, 1)));
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        repeat (12) @(negedge clk);
        stall_n = 0;

        // reset during WAIT
        lat_m = 30;
        set_req(0, 1'b0, 24'h000300, 8'h00);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; req_v[0] = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_m_en", m_en, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_rdata", {p0_rdata, p1_rdata}, 0);
        rst = 1'b0;
        last_m = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
        acc_q.delete();
        snap = ack_cnt;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_ack", ack_cnt - snap, 0);
        lat_m = 4;
        set_req(1, 1'b0, 24'h000010, 8'h00);
        service(w, lat);
        req_v[1] = 1'b0;
        chk("post_rst_latency", lat, 6);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
